// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state
// encodings, default operand width and the signed/unsigned mode values.
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 4;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Values of signed_in.
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/sign_mag_conv.sv
// Combinational conditional two's-complement negate. With i_negate tied to
// the sign bit it yields the magnitude of a signed value; the most negative
// value maps to 2^(W-1), which is still representable as a W-bit unsigned.
module sign_mag_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_value,
    input  logic         i_negate,
    output logic [W-1:0] o_value
);

    logic [W-1:0] w_negated;

    assign w_negated = ~i_value + {{(W-1){1'b0}}, 1'b1};

    // Select the negated or pass-through value.
    always_comb begin
        o_value = i_negate ? w_negated : i_value;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential shift-add multiplier. Operands are converted to
// magnitudes on accept, WIDTH add/shift iterations build the unsigned
// product, and the sign is reapplied when the result register is written.
// The multiplier occupies the low half of the accumulator, so each shift
// moves the next multiplier bit into acc[0] while product bits fill in from
// the top.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [2*WIDTH-1:0]   result_out
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;

    logic               w_mode_signed;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result_final;

    assign w_mode_signed = (signed_in == MODE_SIGNED);
    assign w_accept      = (r_state == ST_IDLE) && start_in;
    assign w_last        = (r_state == ST_CALC) && (r_cnt == LAST_ITER);

    // Operand magnitudes; only negated when signed mode and the sign bit is set.
    sign_mag_conv #(.W(WIDTH)) u_abs_a (
        .i_value  (A_in),
        .i_negate (w_mode_signed & A_in[WIDTH-1]),
        .o_value  (w_a_mag)
    );

    sign_mag_conv #(.W(WIDTH)) u_abs_b (
        .i_value  (B_in),
        .i_negate (w_mode_signed & B_in[WIDTH-1]),
        .o_value  (w_b_mag)
    );

    // One iteration: add the multiplicand to the upper half when the current
    // multiplier bit is set, keep the carry, then shift everything right.
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    // Reapply the product sign to the final accumulator value.
    sign_mag_conv #(.W(2*WIDTH)) u_neg_res (
        .i_value  (w_acc_next),
        .i_negate (r_neg),
        .o_value  (w_result_final)
    );

    // FSM, iteration counter and the busy/done output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_state <= ST_CALC;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture, accumulator iterations and the held result register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_neg   <= w_mode_signed & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_result <= w_result_final;
            end
        end
    end

    assign busy_out   = r_busy;
    assign done_out   = r_done;
    assign result_out = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=4 and a WIDTH=8 instance run against a
// behavioural model (integer products plus a cycles-since-accept timeline),
// with directed literal checks, held-start, mid-CALC reset and random ops.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  start = '0;
    logic [1:0]  sgn = '0;
    logic [7:0]  a_in [2];
    logic [7:0]  b_in [2];
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [7:0]  res4;
    logic [15:0] res8;

    int n_vec = 0;
    int n_err = 0;

    // Model state: 0 = idle, k = k cycles since the accepting edge.
    int          m_phase [2];
    logic [15:0] m_pend  [2];
    logic [15:0] m_res   [2];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start[0]),
        .signed_in  (sgn[0]),
        .A_in       (a_in[0][3:0]),
        .B_in       (b_in[0][3:0]),
        .busy_out   (busy[0]),
        .done_out   (done[0]),
        .result_out (res4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start[1]),
        .signed_in  (sgn[1]),
        .A_in       (a_in[1]),
        .B_in       (b_in[1]),
        .busy_out   (busy[1]),
        .done_out   (done[1]),
        .result_out (res8)
    );

    function automatic int wid(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] dut_res(input int k);
        return (k == 0) ? {8'h00, res4} : res8;
    endfunction

    // Reference product: interpret operands as w-bit integers and multiply.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic s, input int w);
        longint mask, av, bv, p;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural timeline: accept in idle, result at WIDTH cycles, idle at WIDTH+2.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= 0;
                m_res[k]   <= '0;
                m_pend[k]  <= '0;
            end else if (m_phase[k] == 0) begin
                if (start[k]) begin
                    m_phase[k] <= 1;
                    m_pend[k]  <= ref_prod(a_in[k], b_in[k], sgn[k], wid(k));
                end
            end else begin
                if (m_phase[k] == wid(k)) m_res[k] <= m_pend[k];
                m_phase[k] <= (m_phase[k] == wid(k) + 1) ? 0 : m_phase[k] + 1;
            end
        end
    end

    // Every cycle, away from the active edge, compare all outputs with the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy%0d", k), {15'h0, busy[k]},
                  {15'h0, (m_phase[k] >= 1 && m_phase[k] <= wid(k))});
            check($sformatf("done%0d", k), {15'h0, done[k]},
                  {15'h0, (m_phase[k] == wid(k) + 1)});
            check($sformatf("result%0d", k), dut_res(k), m_res[k]);
        end
    end

    // One complete operation on instance k with latency, result and hold checks.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp, input string nm);
        int guard;
        int lat;
        guard = 0;
        while (m_phase[k] != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_idle_wait: instance %0d never idle", nm, k);
        end
        a_in[k]  = a;
        b_in[k]  = b;
        sgn[k]   = s;
        start[k] = 1'b1;
        lat = 0;
        for (int i = 1; i <= wid(k) + 4 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start[k] = 1'b0;
                a_in[k]  = 8'($urandom);
                b_in[k]  = 8'($urandom);
                sgn[k]   = 1'($urandom);
            end
            if (done[k]) lat = i;
        end
        check({nm, "_latency"}, 16'(lat), 16'(wid(k) + 1));
        check({nm, "_result"}, dut_res(k), exp);
        $display("op w=%0d s=%0d a=%h b=%h -> %h (expect %h)", wid(k), s, a, b, dut_res(k), exp);
        @(negedge clk);
        check({nm, "_hold"}, dut_res(k), exp);
        check({nm, "_done_low"}, {15'h0, done[k]}, 16'h0);
    endtask

    initial begin
        int dones;
        logic [7:0] ra, rb;
        logic rs;
        a_in[0] = '0; b_in[0] = '0; a_in[1] = '0; b_in[1] = '0;

        // Reset state, asynchronous: checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {14'h0, busy}, 16'h0);
        check("rst_done", {14'h0, done}, 16'h0);
        check("rst_res4", {8'h0, res4}, 16'h0);
        check("rst_res8", res8, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed products.
        run_op(0, 8'h03, 8'h03, 1'b0, 16'h0009, "u_3x3");
        run_op(0, 8'h09, 8'h02, 1'b0, 16'h0012, "u_9x2");
        run_op(0, 8'h07, 8'h06, 1'b0, 16'h002A, "u_7x6");
        run_op(0, 8'h03, 8'h00, 1'b0, 16'h0000, "u_3x0");
        run_op(0, 8'h09, 8'h02, 1'b1, 16'h00F2, "s_m7x2");
        run_op(0, 8'h08, 8'h08, 1'b1, 16'h0040, "s_m8xm8");
        run_op(0, 8'h0F, 8'h01, 1'b1, 16'h00FF, "s_m1x1");
        run_op(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8_ffxff");
        run_op(1, 8'h80, 8'h7F, 1'b1, 16'hC080, "s8_80x7f");
        run_op(0, 8'h07, 8'h07, 1'b0, 16'h0031, "u_7x7");

        // start_in held high with operands changing every cycle.
        while (m_phase[0] != 0) @(negedge clk);
        start[0] = 1'b1;
        dones = 0;
        for (int i = 0; i < 36; i++) begin
            a_in[0] = 8'($urandom);
            b_in[0] = 8'($urandom);
            sgn[0]  = 1'($urandom);
            @(negedge clk);
            if (done[0]) dones++;
        end
        start[0] = 1'b0;
        check("held_start_dones", 16'(dones), 16'd6);
        $display("held start: %0d products in 36 cycles", dones);
        repeat (8) @(negedge clk);

        // Asynchronous reset between the first and second iteration.
        a_in[0] = 8'h07; b_in[0] = 8'h06; sgn[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", {15'h0, busy[0]}, 16'h0);
        check("midrst_done", {15'h0, done[0]}, 16'h0);
        check("midrst_res4", {8'h0, res4}, 16'h0);
        check("midrst_res8", res8, 16'h0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (done[0]) dones++;
        end
        check("midrst_no_done", 16'(dones), 16'd0);
        $display("mid-CALC reset applied");
        run_op(0, 8'h05, 8'h0D, 1'b1, 16'h00F1, "after_rst");

        // Random operations on both widths.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = 1'($urandom);
                if (i == 0) begin ra = 8'h00; rb = 8'h80; rs = 1'b1; end
                if (k == 0) begin ra = ra & 8'h0F; rb = rb & 8'h0F; end
                run_op(k, ra, rb, rs, ref_prod(ra, rb, rs, wid(k)), $sformatf("rnd%0d_%0d", k, i));
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
